// File: rtl/ramdisk_port.sv
// RAM-disk bridge: CPU bus requests to an SDRAM request/ack channel,
// with posted writes, one pending slot and an ack watchdog.
module ramdisk_port #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clke,
   input  logic        blk_n,
   input  logic [2:0]  page,
   input  logic [15:0] address,
   input  logic        memrd,
   input  logic        memwr,
   input  logic [7:0]  data_in,
   output logic [7:0]  data_out,
   output logic        ready,
   output logic        sd_req,
   output logic        sd_we,
   output logic [18:0] sd_addr,
   output logic [7:0]  sd_wdata,
   input  logic        sd_ack,
   input  logic [7:0]  sd_rdata,
   output logic        err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2
   } state_t;

   localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

   state_t      st_q, st_d;
   logic [7:0]  wd_q, wd_d;
   logic [18:0] addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [7:0]  dout_q, dout_d;
   logic        ready_q, ready_d;
   logic        err_q, err_d;
   logic        pv_q, pv_d;
   logic        pw_q, pw_d;
   logic [18:0] pa_q, pa_d;
   logic [7:0]  pd_q, pd_d;

   logic        req, busy, last, done, tmo, take;
   logic        nv, nw;
   logic [18:0] na;
   logic [7:0]  nd;

   always_comb begin
      req  = clke & ~blk_n & (memrd | memwr);
      busy = (st_q != IDLE);
      last = (wd_q == WD_LAST);
      done = busy & (sd_ack | last);
      tmo  = busy & ~sd_ack & last;
      take = req & ~pv_q;
      // next transaction to start: pending entry first, else a new request
      nv = pv_q | take;
      nw = pv_q ? pw_q : memwr;
      na = pv_q ? pa_q : {page, address};
      nd = pv_q ? pd_q : data_in;

      st_d    = st_q;
      wd_d    = wd_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      dout_d  = dout_q;
      ready_d = ready_q;
      err_d   = err_q;
      pv_d    = pv_q;
      pw_d    = pw_q;
      pa_d    = pa_q;
      pd_d    = pd_q;

      if (busy) wd_d = wd_q + 8'd1;

      if (!busy || done) begin
         if (done) begin
            st_d    = IDLE;
            ready_d = 1'b1;
            pv_d    = 1'b0;
            if (tmo) err_d = 1'b1;
            if (st_q == RD) dout_d = tmo ? 8'hFF : sd_rdata;
         end
         if (nv) begin
            st_d    = nw ? WR : RD;
            addr_d  = na;
            wdata_d = nd;
            wd_d    = 8'd0;
            ready_d = nw;
         end
      end else if (take) begin
         pv_d    = 1'b1;
         pw_d    = memwr;
         pa_d    = {page, address};
         pd_d    = data_in;
         ready_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st_q    <= IDLE;
         wd_q    <= 8'd0;
         addr_q  <= 19'd0;
         wdata_q <= 8'd0;
         dout_q  <= 8'd0;
         ready_q <= 1'b1;
         err_q   <= 1'b0;
         pv_q    <= 1'b0;
         pw_q    <= 1'b0;
         pa_q    <= 19'd0;
         pd_q    <= 8'd0;
      end else begin
         st_q    <= st_d;
         wd_q    <= wd_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         dout_q  <= dout_d;
         ready_q <= ready_d;
         err_q   <= err_d;
         pv_q    <= pv_d;
         pw_q    <= pw_d;
         pa_q    <= pa_d;
         pd_q    <= pd_d;
      end
   end

   assign sd_req   = (st_q != IDLE);
   assign sd_we    = (st_q == WR);
   assign sd_addr  = addr_q;
   assign sd_wdata = wdata_q;
   assign data_out = dout_q;
   assign ready    = ready_q;
   assign err      = err_q;

endmodule

// File: tb/tb_ramdisk_port.sv
// Bench for ramdisk_port: directed scenarios plus random traffic
// checked every cycle against a transaction-queue model.
module tb_ramdisk_port;

   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        clke, blk_n, memrd, memwr, sd_ack;
   logic [2:0]  page;
   logic [15:0] address;
   logic [7:0]  data_in, sd_rdata;
   logic [7:0]  data_out, sd_wdata;
   logic        ready, sd_req, sd_we, err;
   logic [18:0] sd_addr;

   int total = 0;
   int bad = 0;

   ramdisk_port #(.TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .clke(clke), .blk_n(blk_n),
      .page(page), .address(address), .memrd(memrd), .memwr(memwr),
      .data_in(data_in), .data_out(data_out), .ready(ready),
      .sd_req(sd_req), .sd_we(sd_we), .sd_addr(sd_addr),
      .sd_wdata(sd_wdata), .sd_ack(sd_ack), .sd_rdata(sd_rdata),
      .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit        w;
      bit [18:0] a;
      bit [7:0]  d;
   } txn_t;

   // head = transaction on the SDRAM channel, second = pending slot
   txn_t     q[$];
   int       age;
   bit [7:0] m_dout;
   bit       m_err;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      age    = 0;
      m_dout = 8'h00;
      m_err  = 1'b0;
   endtask

   task automatic model_step();
      bit acc, popped;
      int was;
      if (reset) begin
         model_reset();
         return;
      end
      was    = q.size();
      acc    = clke && !blk_n && (memrd || memwr) && (was < 2);
      popped = 0;
      if (was > 0 && (sd_ack || age == TMO - 1)) begin
         if (!q[0].w) m_dout = sd_ack ? sd_rdata : 8'hFF;
         if (!sd_ack) m_err = 1'b1;
         void'(q.pop_front());
         popped = 1;
      end
      if (acc) q.push_back('{memwr, {page, address}, data_in});
      if (popped || was == 0) age = 0;
      else age++;
   endtask

   task automatic compare();
      bit e_req, e_we, e_rdy;
      e_req = (q.size() > 0);
      e_we  = e_req && q[0].w;
      e_rdy = !(q.size() == 2 || (q.size() == 1 && !q[0].w));
      chk("sd_req", 32'(sd_req), 32'(e_req));
      chk("sd_we", 32'(sd_we), 32'(e_we));
      chk("ready", 32'(ready), 32'(e_rdy));
      chk("data_out", 32'(data_out), 32'(m_dout));
      chk("err", 32'(err), 32'(m_err));
      if (e_req) chk("sd_addr", 32'(sd_addr), 32'(q[0].a));
      if (e_we) chk("sd_wdata", 32'(sd_wdata), 32'(q[0].d));
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      compare();
   endtask

   task automatic idle_in();
      clke = 0; blk_n = 1; memrd = 0; memwr = 0; sd_ack = 0;
   endtask

   task automatic bus(bit w, bit [2:0] pg, bit [15:0] a, bit [7:0] d);
      clke = 1; blk_n = 0; memrd = !w; memwr = w;
      page = pg; address = a; data_in = d;
   endtask

   task automatic do_reset();
      #2;
      reset = 1;
      model_reset();
      #1;
      compare();
      cyc();
      reset = 0;
   endtask

   initial begin
      idle_in();
      page = 0; address = 0; data_in = 0; sd_rdata = 0;
      reset = 1;
      model_reset();
      #2;
      chk("rst sd_req", 32'(sd_req), 0);
      chk("rst ready", 32'(ready), 1);
      chk("rst data_out", 32'(data_out), 0);
      chk("rst sd_addr", 32'(sd_addr), 0);
      chk("rst sd_wdata", 32'(sd_wdata), 0);
      chk("rst err", 32'(err), 0);
      cyc();
      reset = 0;

      // posted write
      bus(1, 3'd3, 16'h1234, 8'h5A);
      cyc();
      idle_in();
      chk("wr sd_req", 32'(sd_req), 1);
      chk("wr sd_we", 32'(sd_we), 1);
      chk("wr sd_addr", 32'(sd_addr), 32'h31234);
      chk("wr sd_wdata", 32'(sd_wdata), 32'h5A);
      chk("wr ready", 32'(ready), 1);
      repeat (3) cyc();
      sd_ack = 1;
      cyc();
      sd_ack = 0;
      chk("wr done sd_req", 32'(sd_req), 0);

      // read
      bus(0, 3'd1, 16'h8000, 8'h00);
      cyc();
      idle_in();
      chk("rd ready", 32'(ready), 0);
      chk("rd sd_addr", 32'(sd_addr), 32'h18000);
      chk("rd sd_we", 32'(sd_we), 0);
      cyc();
      sd_ack = 1; sd_rdata = 8'hC3;
      cyc();
      sd_ack = 0;
      chk("rd data_out", 32'(data_out), 32'hC3);
      chk("rd ready done", 32'(ready), 1);

      // back-to-back write then read
      bus(1, 3'd0, 16'h0010, 8'h77);
      cyc();
      bus(0, 3'd0, 16'hA001, 8'h00);
      cyc();
      idle_in();
      chk("b2b ready", 32'(ready), 0);
      sd_ack = 1;
      cyc();
      sd_ack = 0;
      chk("b2b sd_req", 32'(sd_req), 1);
      chk("b2b sd_we", 32'(sd_we), 0);
      chk("b2b sd_addr", 32'(sd_addr), 32'h0A001);
      sd_ack = 1; sd_rdata = 8'h9E;
      cyc();
      sd_ack = 0;
      chk("b2b ready done", 32'(ready), 1);
      chk("b2b data_out", 32'(data_out), 32'h9E);

      // timeout
      bus(0, 3'd2, 16'h0042, 8'h00);
      cyc();
      idle_in();
      repeat (TMO - 1) cyc();
      chk("tmo still req", 32'(sd_req), 1);
      cyc();
      chk("tmo sd_req", 32'(sd_req), 0);
      chk("tmo data_out", 32'(data_out), 32'hFF);
      chk("tmo err", 32'(err), 1);
      chk("tmo ready", 32'(ready), 1);
      bus(0, 3'd2, 16'h0043, 8'h00);
      cyc();
      idle_in();
      sd_ack = 1; sd_rdata = 8'h3C;
      cyc();
      sd_ack = 0;
      chk("tmo err sticky", 32'(err), 1);
      chk("tmo later data", 32'(data_out), 32'h3C);

      // ack in the timeout cycle wins
      do_reset();
      bus(0, 3'd5, 16'h1111, 8'h00);
      cyc();
      idle_in();
      repeat (TMO - 1) cyc();
      sd_ack = 1; sd_rdata = 8'h11;
      cyc();
      sd_ack = 0;
      chk("race data_out", 32'(data_out), 32'h11);
      chk("race err", 32'(err), 0);

      // reset mid-read, then a stray ack
      bus(0, 3'd1, 16'h2222, 8'h00);
      cyc();
      idle_in();
      cyc();
      do_reset();
      chk("rst rd sd_req", 32'(sd_req), 0);
      chk("rst rd ready", 32'(ready), 1);
      chk("rst rd data_out", 32'(data_out), 0);
      sd_ack = 1; sd_rdata = 8'hEE;
      cyc();
      sd_ack = 0;
      chk("late ack data_out", 32'(data_out), 0);
      chk("late ack sd_req", 32'(sd_req), 0);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         bit ack_on;
         ack_on   = ((i / 100) % 3) != 0;
         clke     = 1'($urandom_range(0, 1));
         blk_n    = ($urandom_range(0, 3) == 0);
         memrd    = 1'($urandom_range(0, 1));
         memwr    = 1'($urandom_range(0, 1));
         page     = 3'($urandom);
         address  = 16'($urandom);
         data_in  = 8'($urandom);
         sd_rdata = 8'($urandom);
         sd_ack   = ack_on && ($urandom_range(0, 3) == 0);
         if (i == 1500) do_reset();
         else cyc();
      end

      idle_in();
      cyc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
